aes_frame_loader: RTL and testbench
===================================

# aes_frame_loader

Byte-stream front end for `aes_core`. It receives a framed 8-bit stream carrying a mode header, an optional 128-bit key and a 128-bit text block. It assembles the wide words, pulses `aes_core`'s start for one cycle, and holds key, text and mode stable until the core reports completion. It sits directly upstream of `aes_core`, driving its `start_in`, `en_or_de`, `key_in` and `plain_text_in`, and sampling its `cipher_text_ready_out`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT cycles before the operation is abandoned.

Ports:
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `reset_n`, input, 1: synchronous, active-low reset.
- `s_byte`, input, 8: stream data byte.
- `s_valid`, input, 1: `s_byte` is valid this cycle.
- `s_ready`, output, 1: the loader accepts a byte this cycle.
- `core_start_out`, output, 1: one-cycle start pulse to `aes_core.start_in`.
- `core_en_or_de_out`, output, 1: mode to the core; 1 = encrypt, 0 = decrypt.
- `core_key_out`, output, 128: key to `aes_core.key_in`.
- `core_text_out`, output, 128: block to `aes_core.plain_text_in`.
- `core_done_in`, input, 1: from `aes_core.cipher_text_ready_out`.
- `busy_out`, output, 1: state is not IDLE.
- `frame_err_out`, output, 1: one-cycle pulse on a protocol error or timeout.

## Operation
- Byte transfer: a byte is accepted at a rising edge where `s_valid && s_ready`.
- Header byte layout:
  - bits [7:2] must equal 6'b101010.
  - bit 1 is `new_key`.
  - bit 0 is the mode.
- Payload order:
  - If `new_key`=1, 16 key bytes follow, then 16 text bytes.
  - If `new_key`=0, 16 text bytes follow and the stored key is reused.
- Byte order is MSB first. Each shift register shifts left by 8 and inserts the new byte at [7:0], so the first payload byte lands in [127:120].
- State machine:
  - IDLE accepts the header. A valid header latches the mode, clears the 4-bit byte counter, and moves to KEY if `new_key`=1, otherwise TEXT.
  - KEY accepts 16 bytes; the counter wraps 15→0 and the state moves to TEXT. After the last key byte, `key_loaded`=1.
  - TEXT accepts 16 bytes; the counter wraps 15→0 and the state moves to START.
  - START lasts 1 cycle with `core_start_out`=1, then moves to WAIT.
  - WAIT moves to IDLE on the first cycle with `core_done_in`=1, or after TIMEOUT_CYCLES cycles with a `frame_err_out` pulse.
- `s_ready` = reset_n && state ∈ {IDLE, KEY, TEXT}. It is 0 in START and WAIT, which provides the backpressure.
- Header error (bits [7:2] ≠ 101010): the byte is consumed, `frame_err_out` pulses, and the state stays IDLE.
- Missing key (`new_key`=0 while `key_loaded`=0): the byte is consumed, `frame_err_out` pulses, and the state stays IDLE.
- Output stability:
  - `core_key_out` changes only while in KEY.
  - `core_text_out` changes only while in TEXT.
  - `core_en_or_de_out` changes only on header acceptance.
  - All three are constant from START through WAIT.
- `core_done_in` is ignored in IDLE, KEY, TEXT and START. A done level left over from a previous operation therefore cannot end WAIT early.
- Timeout counter: cleared on entry to WAIT and saturating. It is wide enough for TIMEOUT_CYCLES, i.e. $clog2(TIMEOUT_CYCLES+1) bits.

## Timing
- Reset value (reset_n=0 at an edge):
  - state = IDLE, counter = 0, `key_loaded` = 0.
  - `core_key_out` = 0, `core_text_out` = 0, `core_en_or_de_out` = 0.
  - `core_start_out` = 0, `busy_out` = 0, `frame_err_out` = 0.
  - `s_ready` = 0 while reset_n is low and 1 in the first cycle after release.
- Latency:
  - The last text byte is accepted at edge N.
  - `core_start_out`=1 during cycle N+1 only.
  - WAIT begins at N+2.
- Done and timeout:
  - `core_done_in`=1 sampled in WAIT at edge M puts the state in IDLE with `s_ready`=1 from cycle M+1.
  - On timeout, `frame_err_out` is high in the first IDLE cycle.
- Reset mid-frame or in WAIT: return to the reset state at the next edge. Partial bytes and the stored key are discarded.
- Sustained stream: with `s_valid` held high, the loader accepts one byte per cycle with no bubbles between header, key and text.
- Throughput: a frame with a new key takes 33 accept cycles plus 1 START cycle plus the WAIT cycles.

## Structure
- Package `aes_loader_pkg` holds:
  - the state enum (IDLE, KEY, TEXT, START, WAIT);
  - `HDR_MAGIC` = 6'b101010;
  - `BLOCK_BYTES` = 16;
  - the header bit positions `HDR_NEWKEY_BIT` = 1 and `HDR_MODE_BIT` = 0.
- One sub-module, `aes_byte_shreg128` (8-bit in, shift enable, synchronous clear, 128-bit out), instantiated twice: once for the key, once for the text.

## Test plan
- Decrypt with new key: stream 0xAA, then key 0x…3000 (bytes 00×14, 0x30, 0x00), then text 89bdf4c13a2aa67896d6b2a0f3e0ff4e.
  - `core_key_out`=128'h3000 and `core_text_out`=128'h89bd…ff4e.
  - `core_en_or_de_out`=0 and `core_start_out` is a single pulse one cycle after the last byte.
  - `s_ready`=0 until `core_done_in`.
- Key reuse: after the previous frame, stream 0xA9 plus 16 text bytes.
  - Key is unchanged and `core_en_or_de_out`=1.
  - 17 accepts occur before START.
- Errors:
  - Header 0x55: `frame_err_out` pulses once and the state stays IDLE.
  - Header 0xA8 directly after reset: `frame_err_out` pulses because no key is loaded.
- Stale done: hold `core_done_in`=1 continuously while loading.
  - WAIT is still entered.
  - The loader exits to IDLE at the first WAIT edge, never in START.
- Timeout: with TIMEOUT_CYCLES=8 and `core_done_in`=0, the loader returns to IDLE after 8 WAIT cycles with `frame_err_out` pulsed.
- Reset mid-frame and backpressure:
  - Drop reset_n after key byte 7: all outputs are zero and `key_loaded`=0 (a following 0xA8 header errors).
  - Toggle `s_valid` randomly: the assembled words are unchanged.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared definitions for the aes_frame_loader slice.
// Holds the loader state encoding, the header layout (magic field and flag
// bit positions) and the block size in bytes.
package aes_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_TEXT  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  localparam logic [5:0]  HDR_MAGIC      = 6'b101010;
  localparam int unsigned BLOCK_BYTES    = 16;
  localparam int unsigned HDR_NEWKEY_BIT = 1;
  localparam int unsigned HDR_MODE_BIT   = 0;

  // Header bits [7:2] must carry the magic pattern.
  function automatic logic hdr_magic_ok(input logic [7:0] hdr);
    return hdr[7:2] == HDR_MAGIC;
  endfunction

endpackage

// File: rtl/aes_byte_shreg128.sv
// 128-bit byte-wide shift register, MSB first.
// Ports:
//   clk     - rising-edge clock
//   clr_i   - synchronous clear (wins over shift)
//   shift_i - shift left by one byte, inserting byte_i at [7:0]
//   byte_i  - incoming byte
//   word_o  - assembled 128-bit word
module aes_byte_shreg128 (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic [7:0]   byte_i,
  output logic [127:0] word_o
);

  logic [127:0] word_q;

  always_ff @(posedge clk) begin
    if (clr_i) begin
      word_q <= '0;
    end else if (shift_i) begin
      word_q <= {word_q[119:0], byte_i};
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/aes_frame_loader.sv
// Byte-stream front end for aes_core: parses a header byte, assembles an
// optional 128-bit key and a 128-bit text block, pulses start for one cycle
// and holds key/text/mode stable until the core reports done (or timeout).
// Ports:
//   clk, reset_n          - clock, synchronous active-low reset
//   s_byte/s_valid/s_ready - input byte stream handshake
//   core_start_out        - one-cycle start pulse to aes_core
//   core_en_or_de_out     - 1 = encrypt, 0 = decrypt
//   core_key_out          - key word to aes_core
//   core_text_out         - text block to aes_core
//   core_done_in          - completion from aes_core
//   busy_out              - loader not idle
//   frame_err_out         - one-cycle pulse on header error or timeout
module aes_frame_loader
  import aes_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [7:0]   s_byte,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         core_start_out,
  output logic         core_en_or_de_out,
  output logic [127:0] core_key_out,
  output logic [127:0] core_text_out,
  input  logic         core_done_in,
  output logic         busy_out,
  output logic         frame_err_out
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]    CNT_LAST = 4'(BLOCK_BYTES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          key_loaded_q, key_loaded_d;
  logic          mode_q, mode_d;
  logic          err_q, err_d;
  logic          accept;

  assign s_ready = reset_n &&
                   (state_q == ST_IDLE || state_q == ST_KEY || state_q == ST_TEXT);
  assign accept  = s_valid && s_ready;

  aes_byte_shreg128 u_key_shreg (
    .clk     (clk),
    .clr_i   (~reset_n),
    .shift_i (accept && state_q == ST_KEY),
    .byte_i  (s_byte),
    .word_o  (core_key_out)
  );

  aes_byte_shreg128 u_text_shreg (
    .clk     (clk),
    .clr_i   (~reset_n),
    .shift_i (accept && state_q == ST_TEXT),
    .byte_i  (s_byte),
    .word_o  (core_text_out)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    to_d         = to_q;
    key_loaded_d = key_loaded_q;
    mode_d       = mode_q;
    err_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!hdr_magic_ok(s_byte)) begin
            err_d = 1'b1;
          end else if (!s_byte[HDR_NEWKEY_BIT] && !key_loaded_q) begin
            err_d = 1'b1;
          end else begin
            mode_d  = s_byte[HDR_MODE_BIT];
            cnt_d   = '0;
            state_d = s_byte[HDR_NEWKEY_BIT] ? ST_KEY : ST_TEXT;
          end
        end
      end
      ST_KEY: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d      = ST_TEXT;
            key_loaded_d = 1'b1;
          end
        end
      end
      ST_TEXT: begin
        if (accept) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
        to_d    = '0;
      end
      ST_WAIT: begin
        // Done is only honoured here, so a level left high from an earlier
        // operation cannot end the wait before this operation's start.
        if (core_done_in) begin
          state_d = ST_IDLE;
        end else if (to_q == TO_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (to_q != TO_MAX) begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      to_q         <= '0;
      key_loaded_q <= 1'b0;
      mode_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      to_q         <= to_d;
      key_loaded_q <= key_loaded_d;
      mode_q       <= mode_d;
      err_q        <= err_d;
    end
  end

  assign core_start_out    = (state_q == ST_START);
  assign core_en_or_de_out = mode_q;
  assign busy_out          = (state_q != ST_IDLE);
  assign frame_err_out     = err_q;

endmodule

// File: tb/tb_aes_frame_loader.sv
module tb_aes_frame_loader;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   s_byte = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic         core_start_out;
  logic         core_en_or_de_out;
  logic [127:0] core_key_out;
  logic [127:0] core_text_out;
  logic         core_done_in = 1'b0;
  logic         busy_out;
  logic         frame_err_out;

  always #5 clk = ~clk;

  aes_frame_loader #(.TIMEOUT_CYCLES(8)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .s_byte            (s_byte),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .core_start_out    (core_start_out),
    .core_en_or_de_out (core_en_or_de_out),
    .core_key_out      (core_key_out),
    .core_text_out     (core_text_out),
    .core_done_in      (core_done_in),
    .busy_out          (busy_out),
    .frame_err_out     (frame_err_out)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit           is_err;
    logic [127:0] key;
    logic [127:0] text;
    logic         mode;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  // Reference model state: the key the loader should currently hold.
  logic [127:0] m_key = '0;
  bit           m_key_valid = 0;
  logic [127:0] m_text = '0;
  int           acc_count;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every start pulse or error pulse must match the next expectation.
  always @(negedge clk) begin
    if (reset_n && (core_start_out || frame_err_out)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: start=%0b err=%0b with nothing expected",
                 core_start_out, frame_err_out);
      end else begin
        e_mon = sb.pop_front();
        check("sb_kind_err", 128'(frame_err_out), 128'(e_mon.is_err));
        if (!e_mon.is_err && core_start_out) begin
          check("sb_key", core_key_out, e_mon.key);
          check("sb_text", core_text_out, e_mon.text);
          check("sb_mode", 128'(core_en_or_de_out), 128'(e_mon.mode));
        end
      end
    end
  end

  // Model of one frame: decides acceptance from the header rules and queues
  // the response the loader must produce.
  task automatic model_issue(input logic [7:0] hdr, input logic [127:0] k,
                             input logic [127:0] t, output bit ok);
    exp_t e;
    if (hdr[7:2] != 6'b101010 || (!hdr[1] && !m_key_valid)) begin
      ok = 0;
      e = '{is_err: 1'b1, key: '0, text: '0, mode: 1'b0};
    end else begin
      ok = 1;
      if (hdr[1]) begin
        m_key = k;
        m_key_valid = 1;
      end
      m_text = t;
      e = '{is_err: 1'b0, key: m_key, text: t, mode: hdr[0]};
    end
    sb.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit got;
    int tries;
    got = 0;
    tries = 0;
    while (!got) begin
      @(negedge clk);
      s_byte  = b;
      s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      #1;
      got = s_valid && s_ready;
      @(posedge clk);
      tries++;
      if (!got && tries > 200) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: byte %h never accepted", b);
        got = 1;
      end
    end
    acc_count++;
  endtask

  task automatic send_word(input logic [127:0] w, input bit gaps);
    for (int i = 0; i < 16; i++) send_byte(w[127-8*i -: 8], gaps);
  endtask

  // Sends a frame and checks the cycle right after its final accept.
  task automatic do_frame(input logic [7:0] hdr, input logic [127:0] k,
                          input logic [127:0] t, input bit gaps, output bit ok);
    model_issue(hdr, k, t, ok);
    acc_count = 0;
    send_byte(hdr, gaps);
    if (ok) begin
      if (hdr[1]) send_word(k, gaps);
      send_word(t, gaps);
    end
    @(negedge clk);
    s_valid = 1'b0;
    if (ok) begin
      check("start_latency", 128'(core_start_out), 128'(1));
      check("start_no_ready", 128'(s_ready), 128'(0));
    end else begin
      check("err_pulse", 128'(frame_err_out), 128'(1));
      check("err_stays_idle", 128'(busy_out), 128'(0));
      @(negedge clk);
      check("err_single_pulse", 128'(frame_err_out), 128'(0));
      check("err_ready", 128'(s_ready), 128'(1));
    end
  endtask

  // Called at the negedge of the START cycle; waits, then answers with done.
  task automatic finish_op(input int delay);
    @(negedge clk);
    check("start_one_cycle", 128'(core_start_out), 128'(0));
    check("wait_busy", 128'(busy_out), 128'(1));
    for (int i = 0; i < delay; i++) begin
      check("wait_no_ready", 128'(s_ready), 128'(0));
      check("wait_key_stable", core_key_out, m_key);
      check("wait_text_stable", core_text_out, m_text);
      @(negedge clk);
    end
    core_done_in = 1'b1;
    @(negedge clk);
    core_done_in = 1'b0;
    check("done_ready", 128'(s_ready), 128'(1));
    check("done_idle", 128'(busy_out), 128'(0));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_key"}, core_key_out, '0);
    check({tag, "_text"}, core_text_out, '0);
    check({tag, "_mode"}, 128'(core_en_or_de_out), 128'(0));
    check({tag, "_start"}, 128'(core_start_out), 128'(0));
    check({tag, "_busy"}, 128'(busy_out), 128'(0));
    check({tag, "_err"}, 128'(frame_err_out), 128'(0));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    s_valid = 1'b0;
    core_done_in = 1'b0;
    #1;
    check("reset_no_ready", 128'(s_ready), 128'(0));
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_no_ready2", 128'(s_ready), 128'(0));
    m_key_valid = 0;
    m_key = '0;
    reset_n = 1'b1;
    @(negedge clk);
    check("release_ready", 128'(s_ready), 128'(1));
  endtask

  bit           ok;
  logic [127:0] rk, rt;
  logic [7:0]   hdr;
  int           nwait;

  initial begin
    apply_reset();

    // No key loaded yet, then a bad magic.
    do_frame(8'hA8, '0, '0, 0, ok);
    do_frame(8'h55, '0, '0, 0, ok);

    // Directed decrypt with a new key.
    do_frame(8'hAA, 128'h3000, 128'h89bdf4c13a2aa67896d6b2a0f3e0ff4e, 0, ok);
    check("directed_accepts", 128'(acc_count), 128'(33));
    check("directed_key", core_key_out, 128'h3000);
    check("directed_text", core_text_out, 128'h89bdf4c13a2aa67896d6b2a0f3e0ff4e);
    check("directed_mode", 128'(core_en_or_de_out), 128'(0));
    finish_op(3);

    // Key reuse, encrypt.
    rt = {$urandom, $urandom, $urandom, $urandom};
    do_frame(8'hA9, '0, rt, 0, ok);
    check("reuse_accepts", 128'(acc_count), 128'(17));
    check("reuse_key", core_key_out, 128'h3000);
    check("reuse_mode", 128'(core_en_or_de_out), 128'(1));
    finish_op(1);

    // Randomized frames with random backpressure and occasional junk headers.
    for (int n = 0; n < 8; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rt = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 4) == 0) hdr = 8'($urandom);
      else hdr = {6'b101010, 1'($urandom), 1'($urandom)};
      do_frame(hdr, rk, rt, $urandom_range(0, 1) == 1, ok);
      if (ok) finish_op($urandom_range(0, 4));
    end

    // Stale done held high through the whole load.
    core_done_in = 1'b1;
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom, $urandom, $urandom};
    do_frame(8'hAB, rk, rt, 0, ok);
    @(negedge clk);
    check("stale_wait_entered", 128'(busy_out), 128'(1));
    check("stale_wait_no_ready", 128'(s_ready), 128'(0));
    @(negedge clk);
    check("stale_exit_idle", 128'(busy_out), 128'(0));
    check("stale_exit_ready", 128'(s_ready), 128'(1));
    core_done_in = 1'b0;

    // Reset after key byte 7 discards the stored key.
    send_byte(8'hAB, 0);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    apply_reset();
    do_frame(8'hA8, '0, '0, 0, ok);

    // Timeout: no done, exactly 8 WAIT cycles then an error pulse.
    rk = {$urandom, $urandom, $urandom, $urandom};
    rt = {$urandom, $urandom, $urandom, $urandom};
    do_frame(8'hAA, rk, rt, 1, ok);
    sb.push_back('{is_err: 1'b1, key: '0, text: '0, mode: 1'b0});
    nwait = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy_out) break;
      nwait++;
    end
    check("timeout_wait_cycles", 128'(nwait), 128'(8));
    check("timeout_err", 128'(frame_err_out), 128'(1));
    check("timeout_ready", 128'(s_ready), 128'(1));

    repeat (3) @(negedge clk);
    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
